// File: rtl/video_led_pkg.sv
// Shared LED mode encoding and per-LED output decode for the video LED pattern source.
package video_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF  = 2'd0,
        LED_ON   = 2'd1,
        LED_SLOW = 2'd2,
        LED_FAST = 2'd3
    } led_mode_t;

    localparam int C_LED_N_DEF = 18;

    function automatic logic led_bit(led_mode_t m, logic slow, logic fast);
        unique case (m)
            LED_OFF:  return 1'b0;
            LED_ON:   return 1'b1;
            LED_SLOW: return slow;
            LED_FAST: return fast;
        endcase
    endfunction

endpackage

// File: rtl/video_frame_div.sv
// Frame-count divider: phase toggles every N enabled frame strobes (period 2*N frames).
module video_frame_div #(
    parameter int N = 30
) (
    input  logic CK_i,
    input  logic XRST_i,
    input  logic CK_EE_i,
    input  logic FRAME_i,
    output logic PHASE_o,
    output logic PHASE_D_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (CK_EE_i && FRAME_i) begin
            if (cnt_q == CW'(N - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CK_i) begin
        if (!XRST_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Next-state phase lets the top register the post-update pattern on the same strobe.
    assign PHASE_o   = phase_q;
    assign PHASE_D_o = phase_d;

endmodule

// File: rtl/video_led_pattern.sv
// Frame-synchronous LED pattern source: shadow/active mode banks, frame-aligned commit, blink dividers.
module video_led_pattern
    import video_led_pkg::*;
#(
    parameter int C_LED_N   = C_LED_N_DEF,
    parameter int C_SLOW_FR = 30,
    parameter int C_FAST_FR = 8
) (
    input  logic               CK_i,
    input  logic               XRST_i,
    input  logic               CK_EE_i,
    input  logic               FRAME_i,
    input  logic               WR_i,
    output logic               WR_RDY_o,
    input  logic [4:0]         WR_IDXs_i,
    input  logic [1:0]         WR_MODEs_i,
    input  logic               COMMIT_i,
    output logic               PEND_o,
    output logic [C_LED_N-1:0] LEDs_ON_o
);

    logic [C_LED_N-1:0][1:0] shadow_q, shadow_d;
    logic [C_LED_N-1:0][1:0] active_q, active_d;
    logic                    pend_q, pend_d;
    logic [C_LED_N-1:0]      led_q, led_d;
    logic                    slow_ph, slow_ph_d, fast_ph, fast_ph_d;
    logic                    act, wr_fire, commit_exec, frame_act;

    video_frame_div #(.N(C_SLOW_FR)) u_slow (
        .CK_i(CK_i), .XRST_i(XRST_i), .CK_EE_i(CK_EE_i), .FRAME_i(FRAME_i),
        .PHASE_o(slow_ph), .PHASE_D_o(slow_ph_d)
    );

    video_frame_div #(.N(C_FAST_FR)) u_fast (
        .CK_i(CK_i), .XRST_i(XRST_i), .CK_EE_i(CK_EE_i), .FRAME_i(FRAME_i),
        .PHASE_o(fast_ph), .PHASE_D_o(fast_ph_d)
    );

    assign act         = CK_EE_i & XRST_i;
    assign WR_RDY_o    = ~pend_q & XRST_i;
    assign wr_fire     = act & WR_i & WR_RDY_o;
    assign frame_act   = act & FRAME_i;
    assign commit_exec = frame_act & pend_q;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        led_d    = led_q;
        // Out-of-range indices complete the handshake but match no slot.
        for (int i = 0; i < C_LED_N; i++) begin
            if (wr_fire && WR_IDXs_i == 5'(i))
                shadow_d[i] = WR_MODEs_i;
        end
        if (commit_exec) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end else if (act && COMMIT_i) begin
            pend_d = 1'b1;
        end
        if (frame_act) begin
            for (int i = 0; i < C_LED_N; i++)
                led_d[i] = led_bit(led_mode_t'(active_d[i]), slow_ph_d, fast_ph_d);
        end
    end

    always_ff @(posedge CK_i) begin
        if (!XRST_i) begin
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            led_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            led_q    <= led_d;
        end
    end

    assign PEND_o    = pend_q;
    assign LEDs_ON_o = led_q;

endmodule

// File: tb/tb_video_led_pattern.sv
// Randomized + directed bench for video_led_pattern against a frame-count reference model.
module tb_video_led_pattern;

    localparam int NL   = 18;
    localparam int SLOW = 2;
    localparam int FAST = 1;

    logic          CK_i = 1'b0;
    logic          XRST_i = 1'b0, CK_EE_i = 1'b0, FRAME_i = 1'b0;
    logic          WR_i = 1'b0, COMMIT_i = 1'b0;
    logic [4:0]    WR_IDXs_i = '0;
    logic [1:0]    WR_MODEs_i = '0;
    logic          WR_RDY_o, PEND_o;
    logic [NL-1:0] LEDs_ON_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: mode arrays, pending flag, and total enabled frames since reset.
    int m_shadow[NL];
    int m_act[NL];
    int m_pend;
    int m_frames;
    logic [NL-1:0] m_led;

    video_led_pattern #(.C_LED_N(NL), .C_SLOW_FR(SLOW), .C_FAST_FR(FAST)) dut (
        .CK_i(CK_i), .XRST_i(XRST_i), .CK_EE_i(CK_EE_i), .FRAME_i(FRAME_i),
        .WR_i(WR_i), .WR_RDY_o(WR_RDY_o), .WR_IDXs_i(WR_IDXs_i), .WR_MODEs_i(WR_MODEs_i),
        .COMMIT_i(COMMIT_i), .PEND_o(PEND_o), .LEDs_ON_o(LEDs_ON_o)
    );

    always #5 CK_i = ~CK_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int old_pend;
        int slow_ph, fast_ph;
        if (!XRST_i) begin
            foreach (m_shadow[i]) m_shadow[i] = 0;
            foreach (m_act[i]) m_act[i] = 0;
            m_pend = 0; m_frames = 0; m_led = '0;
        end else if (CK_EE_i) begin
            old_pend = m_pend;
            if (FRAME_i) m_frames++;
            if (FRAME_i && old_pend) begin
                foreach (m_act[i]) m_act[i] = m_shadow[i];
                m_pend = 0;
            end else if (COMMIT_i && !old_pend) begin
                m_pend = 1;
            end
            if (WR_i && !old_pend && WR_IDXs_i < NL) m_shadow[WR_IDXs_i] = WR_MODEs_i;
            if (FRAME_i) begin
                slow_ph = (m_frames / SLOW) % 2;
                fast_ph = (m_frames / FAST) % 2;
                foreach (m_act[i])
                    m_led[i] = (m_act[i] == 1) ? 1'b1 :
                               (m_act[i] == 2) ? slow_ph[0] :
                               (m_act[i] == 3) ? fast_ph[0] : 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic rst_n, input logic ee, input logic fr, input logic wr,
                       input logic [4:0] idx, input logic [1:0] mode, input logic cm);
        XRST_i = rst_n; CK_EE_i = ee; FRAME_i = fr; WR_i = wr;
        WR_IDXs_i = idx; WR_MODEs_i = mode; COMMIT_i = cm;
        @(posedge CK_i);
        model_edge();
        #1;
        chk("leds", 32'(LEDs_ON_o), 32'(m_led));
        chk("pend", 32'(PEND_o), 32'(m_pend));
        chk("rdy", 32'(WR_RDY_o), 32'((m_pend == 0) && rst_n));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held with a write request: nothing may land.
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1, 5'd3, 2'd1, 0);
        chk("rst_rdy", 32'(WR_RDY_o), 32'd0);
        chk("rst_leds", 32'(LEDs_ON_o), 32'd0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("rst_nowrite", 32'(LEDs_ON_o), 32'd0);

        // Basic write then commit.
        cyc(1, 1, 0, 1, 5'd3, 2'd1, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        chk("cm_pend", 32'(PEND_o), 32'd1);
        chk("cm_rdy", 32'(WR_RDY_o), 32'd0);
        idle(3);
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("cm_led", 32'(LEDs_ON_o), 32'h00008);
        chk("cm_rdy1", 32'(WR_RDY_o), 32'd1);

        // Blink: idx0 slow, idx1 fast, idx3 off; 8 frames with gaps.
        cyc(1, 1, 0, 1, 5'd0, 2'd2, 0);
        cyc(1, 1, 0, 1, 5'd1, 2'd3, 0);
        cyc(1, 1, 0, 1, 5'd3, 2'd0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0);
        for (int f = 0; f < 8; f++) begin
            idle(3);
            cyc(1, 1, 1, 0, 0, 0, 0);
        end

        // Commit with frame in same cycle: copy deferred one frame; write-with-commit included.
        cyc(1, 1, 1, 1, 5'd5, 2'd1, 1);
        chk("coll_pend", 32'(PEND_o), 32'd1);
        chk("coll_nocopy", 32'(LEDs_ON_o[5]), 32'd0);
        cyc(1, 1, 0, 1, 5'd6, 2'd1, 0);  // stalled while pending
        idle(2);
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("coll_copy", 32'(LEDs_ON_o[6:5]), 32'h1);

        // Out-of-range index, then frame with clock enable low.
        cyc(1, 1, 0, 1, 5'd31, 2'd1, 1);
        cyc(1, 0, 1, 0, 0, 0, 0);
        chk("ee0_pend", 32'(PEND_o), 32'd1);
        cyc(1, 1, 1, 0, 0, 0, 0);

        // Reset while pending discards the commit.
        cyc(1, 1, 0, 1, 5'd2, 2'd1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rstp_pend", 32'(PEND_o), 32'd0);
        chk("rstp_leds", 32'(LEDs_ON_o), 32'd0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("rstp_after", 32'(LEDs_ON_o), 32'd0);

        // Random traffic.
        for (int k = 0; k < 3000; k++)
            cyc(($urandom_range(63) != 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
                $urandom_range(1), 5'($urandom_range(31)), 2'($urandom_range(3)),
                ($urandom_range(15) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
